// File: rtl/mux_4to1_arbiter_pkg.sv
// Shared types and the round-robin pick function for the 4-to-1 mux arbiter.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // First set request in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4),
    // ignoring any requester flagged in excl.
    function automatic pick_t rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [SEL_W-1:0]   ptr,
        input logic [NUM_REQ-1:0] excl
    );
        pick_t            res;
        logic [NUM_REQ-1:0] cand;
        logic [SEL_W-1:0] pos;
        res.found = 1'b0;
        res.idx   = '0;
        cand      = req & ~excl;
        // Walk from the far end so the closest-to-ptr hit is written last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = ptr + SEL_W'(k);
            if (cand[pos]) begin
                res.found = 1'b1;
                res.idx   = pos;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux_4to1_arbiter_if.sv
// Request/data/grant bundle between the requesters and the arbiter.
interface mux_4to1_arbiter_if;
    import mux_arb_pkg::*;

    logic [NUM_REQ-1:0] REQ;
    logic               A;
    logic               B;
    logic               C;
    logic               D;
    logic [NUM_REQ-1:0] GNT;
    logic               S0;
    logic               S1;
    logic               Y;
    logic               VALID;

    modport master (
        output REQ, A, B, C, D,
        input  GNT, S0, S1, Y, VALID
    );

    modport slave (
        input  REQ, A, B, C, D,
        output GNT, S0, S1, Y, VALID
    );

endinterface

// File: rtl/mux_4to1_arbiter_gate.sv
// Plain 4-to-1 single-bit mux: {S1,S0} = 00 A, 01 B, 10 C, 11 D.
module mux_4to1_gate (
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    input  logic S0,
    input  logic S1,
    output logic Y
);

    // Select one data bit by the two select lines.
    always_comb begin
        Y = 1'b0;
        case ({S1, S0})
            2'b00:   Y = A;
            2'b01:   Y = B;
            2'b10:   Y = C;
            default: Y = D;
        endcase
    end

endmodule

// File: rtl/mux_4to1_arbiter.sv
// Round-robin arbiter owning the select lines of the shared 4-to-1 mux.
//
// state | meaning
// IDLE  | no grant; S1/S0 keep the last owner's index
// GRANT | exactly one GNT bit high, owner drives Y
module mux_4to1_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic                CLK,
    input  logic                RST,
    mux_4to1_arbiter_if.slave   bus
);

    localparam int HCNT_W = $clog2(MAX_HOLD + 1);

    arb_state_t         state;
    logic [SEL_W-1:0]   owner;
    logic [SEL_W-1:0]   ptr;
    logic [HCNT_W-1:0]  hcnt;
    logic [NUM_REQ-1:0] gnt;

    logic [NUM_REQ-1:0] owner_mask;
    pick_t              pick_any;
    pick_t              pick_other;
    logic               mux_y;
    logic               hold_full;

    // Candidate winners: any requester (from IDLE) or anyone but the owner.
    always_comb begin
        owner_mask = NUM_REQ'(1) << owner;
        pick_any   = rr_pick(bus.REQ, ptr, '0);
        pick_other = rr_pick(bus.REQ, ptr, owner_mask);
        hold_full  = (hcnt == HCNT_W'(MAX_HOLD));
    end

    // Arbiter FSM: grant, hand over, rotate on hold limit, or release.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
            hcnt  <= '0;
            gnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any.found) begin
                        state <= GRANT;
                        owner <= pick_any.idx;
                        ptr   <= pick_any.idx + SEL_W'(1);
                        hcnt  <= HCNT_W'(1);
                        gnt   <= NUM_REQ'(1) << pick_any.idx;
                    end
                end
                GRANT: begin
                    if ((!bus.REQ[owner] || hold_full) && pick_other.found) begin
                        owner <= pick_other.idx;
                        ptr   <= pick_other.idx + SEL_W'(1);
                        hcnt  <= HCNT_W'(1);
                        gnt   <= NUM_REQ'(1) << pick_other.idx;
                    end else if (!bus.REQ[owner]) begin
                        state <= IDLE;
                        gnt   <= '0;
                    end else if (!hold_full) begin
                        hcnt  <= hcnt + HCNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    mux_4to1_gate u_mux (
        .A  (bus.A),
        .B  (bus.B),
        .C  (bus.C),
        .D  (bus.D),
        .S0 (owner[0]),
        .S1 (owner[1]),
        .Y  (mux_y)
    );

    // Outputs: selects straight from the owner register, data gated by VALID.
    assign bus.GNT   = gnt;
    assign bus.S0    = owner[0];
    assign bus.S1    = owner[1];
    assign bus.VALID = |gnt;
    assign bus.Y     = mux_y & (|gnt);

endmodule

// File: tb/tb_mux_4to1_arbiter.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, monitor compares.
module tb_mux_4to1_arbiter;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    mux_4to1_arbiter_if bus ();

    mux_4to1_arbiter #(.MAX_HOLD(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic       y;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Drive one cycle of stimulus at the falling edge and queue the state
    // expected right after the following rising edge.
    task automatic step(input string nm, input logic rst, input logic [3:0] req,
                        input logic [3:0] dat, input logic [3:0] eg,
                        input logic [1:0] es, input logic ev, input logic ey);
        exp_t e;
        @(negedge CLK);
        RST = rst;
        bus.REQ = req;
        {bus.D, bus.C, bus.B, bus.A} = dat;
        e.name  = nm;
        e.gnt   = eg;
        e.sel   = es;
        e.valid = ev;
        e.y     = ey;
        q.push_back(e);
    endtask

    // Monitor: one expectation per rising edge once stimulus has queued it.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_checks++;
                if (bus.GNT !== e.gnt || {bus.S1, bus.S0} !== e.sel ||
                    bus.VALID !== e.valid || bus.Y !== e.y) begin
                    n_fail++;
                    $display("FAIL %s: got gnt=%b sel=%b valid=%b y=%b, expected gnt=%b sel=%b valid=%b y=%b",
                             e.name, bus.GNT, {bus.S1, bus.S0}, bus.VALID, bus.Y,
                             e.gnt, e.sel, e.valid, e.y);
                end
            end
        end
    end

    // Mid-cycle check of the combinational data path.
    task automatic comb_check(input string nm, input logic [3:0] dat, input logic ey);
        {bus.D, bus.C, bus.B, bus.A} = dat;
        #1;
        n_checks++;
        if (bus.Y !== ey) begin
            n_fail++;
            $display("FAIL %s: got y=%b, expected y=%b", nm, bus.Y, ey);
        end
    endtask

    initial begin
        logic [3:0] dat;
        logic [3:0] walk [6];
        int idx;
        int budget;

        bus.REQ = 4'b0000;
        {bus.D, bus.C, bus.B, bus.A} = 4'b0000;

        // Reset state, with A high to show Y is gated by VALID.
        step("reset0", 1'b1, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0);
        step("reset1", 1'b1, 4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0);

        // Single request from A, then release.
        step("a_grant",   1'b0, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1);
        step("a_release", 1'b0, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0);

        // All four requesting: A,B,C,D,A, four cycles each, no idle gap.
        step("rr_reset", 1'b1, 4'b0000, 4'b0101, 4'b0000, 2'd0, 1'b0, 1'b0);
        dat = 4'b0101;
        for (int k = 0; k < 17; k++) begin
            idx = (k / 4) % 4;
            step("rr_1111", 1'b0, 4'b1111, dat, 4'b0001 << idx, 2'(idx), 1'b1, dat[idx]);
        end

        // A drops, C takes over (PTR=1) and stays alone past the hold limit.
        step("c_take", 1'b0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1);
        for (int k = 0; k < 19; k++)
            step("c_alone", 1'b0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1);
        // Hold count already saturated, so D wins on the first contended edge.
        step("c_to_d",  1'b0, 4'b1100, 4'b1100, 4'b1000, 2'd3, 1'b1, 1'b1);
        step("d_keeps", 1'b0, 4'b1100, 4'b0100, 4'b1000, 2'd3, 1'b1, 1'b0);

        // B owner drops with A and D pending: PTR=2 makes D win, no bubble.
        step("bd_reset", 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        step("b_only",   1'b0, 4'b0010, 4'b1011, 4'b0010, 2'd1, 1'b1, 1'b1);
        step("b_drop",   1'b0, 4'b1001, 4'b1011, 4'b1000, 2'd3, 1'b1, 1'b1);
        step("d_hold",   1'b0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0);

        // Reset mid-grant of D ignores REQ; B wins first after release.
        step("rst_mid",  1'b1, 4'b1000, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
        step("post_rst", 1'b0, 4'b1010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1);

        // Data walk with B fixed as owner.
        walk[0] = 4'b0000; walk[1] = 4'b1101; walk[2] = 4'b0010;
        walk[3] = 4'b1111; walk[4] = 4'b1010; walk[5] = 4'b0101;
        for (int k = 0; k < 6; k++) begin
            dat = walk[k];
            step("data_walk", 1'b0, 4'b0010, dat, 4'b0010, 2'd1, 1'b1, dat[1]);
        end

        // Change data away from any edge; Y must follow B immediately.
        @(negedge CLK);
        comb_check("comb_b_hi", 4'b0010, 1'b1);
        comb_check("comb_b_lo", 4'b1101, 1'b0);
        comb_check("comb_b_hi2", 4'b1110, 1'b1);

        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            @(posedge CLK);
            budget--;
        end
        #2;
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending, expected 0 pending", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
